// File: rtl/ifetch_mem_responder_pkg.sv
// Shared encodings for the instruction-fetch / page-table-walk memory responder.
package ifetch_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_PTW   = 1'b1
    } owner_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_mem_responder.sv
// Single-outstanding memory read port shared by the IFU and the MMU page-table walker.
// The PTW has fixed priority, and fetch flushes discard or abandon the response.
module ifetch_mem_responder
    import ifetch_mem_responder_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req_valid_i,
    input  logic [31:0] fetch_addr_i,
    input  logic        fetch_flush_i,
    output logic [31:0] fetch_rdata_o,
    output logic        fetch_rdata_valid_o,
    output logic        fetch_fault_o,
    input  logic        ptw_req_i,
    input  logic [31:0] ptw_addr_i,
    output logic [31:0] ptw_rdata_o,
    output logic        ptw_rvalid_o,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_addr_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic [1:0]  dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);

    state_t           state_q, state_d;
    owner_t           owner_q, owner_d;
    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             drop_timed_q, drop_timed_d;
    logic             fetch_own, cnt_expire;

    assign cnt_inc    = cnt_q + CNT_W'(1);
    assign cnt_expire = (cnt_inc == CNT_LIMIT);
    assign fetch_own  = (owner_q == OWN_FETCH);
    assign mem_addr_o = word_align(addr_q);
    assign dbg_state  = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_FETCH;
            addr_q       <= '0;
            cnt_q        <= '0;
            drop_timed_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            drop_timed_q <= drop_timed_d;
        end
    end

    // Memory handshake: a request transfers on a rising edge where mem_req_valid_o and
    // mem_req_ready_i are both high; valid is held and mem_addr_o is stable until then.
    always_comb begin
        state_d             = state_q;
        owner_d             = owner_q;
        addr_d              = addr_q;
        cnt_d               = cnt_q;
        drop_timed_d        = drop_timed_q;
        mem_req_valid_o     = 1'b0;
        fetch_rdata_o       = '0;
        fetch_rdata_valid_o = 1'b0;
        fetch_fault_o       = 1'b0;
        ptw_rdata_o         = '0;
        ptw_rvalid_o        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A fetch raised alongside a redirect is stale, so it is not granted.
                if (ptw_req_i) begin
                    owner_d = OWN_PTW;
                    addr_d  = ptw_addr_i;
                    state_d = ST_REQ;
                end else if (fetch_req_valid_i && !fetch_flush_i) begin
                    owner_d = OWN_FETCH;
                    addr_d  = fetch_addr_i;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req_valid_o = 1'b1;
                if (fetch_own && fetch_flush_i) begin
                    // If memory took the request this same edge its reply must still be drained.
                    state_d      = mem_req_ready_i ? ST_DROP : ST_IDLE;
                    drop_timed_d = 1'b0;
                end else if (mem_req_ready_i) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_inc;
                if (mem_rvalid_i) begin
                    state_d = ST_IDLE;
                    if (!fetch_own) begin
                        ptw_rvalid_o = 1'b1;
                        ptw_rdata_o  = mem_err_i ? 32'h0 : mem_rdata_i;
                    end else if (!fetch_flush_i) begin
                        fetch_rdata_valid_o = 1'b1;
                        fetch_rdata_o       = mem_rdata_i;
                        fetch_fault_o       = mem_err_i;
                    end
                end else if (fetch_own && fetch_flush_i) begin
                    state_d      = ST_DROP;
                    drop_timed_d = 1'b0;
                end else if (cnt_expire) begin
                    state_d      = ST_DROP;
                    drop_timed_d = 1'b1;
                    cnt_d        = '0;
                    if (fetch_own) begin
                        fetch_rdata_valid_o = 1'b1;
                        fetch_fault_o       = 1'b1;
                    end else begin
                        ptw_rvalid_o = 1'b1;
                    end
                end
            end
            ST_DROP: begin
                if (mem_rvalid_i) begin
                    state_d = ST_IDLE;
                end else if (drop_timed_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_expire) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
